// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage. Holds the PC, looks it up in a small
//   direct-mapped instruction cache and hands one instruction per cycle to
//   decode. On a miss, one full line is requested from memory, installed,
//   and the access is replayed once memory acknowledges the fill.
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   reset           : synchronous, active-high
//   PCbranch        : redirect target (bits [1:0] are ignored)
//   branch_hit      : load the PC from PCbranch (qualified by wrt_en)
//   wrt_en          : PC write enable, 0 stalls the PC
//   instr_from_mem  : fill line, word 0 in the least significant bits
//   mem_data_rdy    : instr_from_mem is valid (used only while requesting)
//   data_filled_ack : memory has retired the request (used only after fill)
//   PCnext          : value the PC takes at the next edge
//   instruction     : fetched instruction, 0 while not hitting
//   reqI_mem        : line request to memory
//   reqAddrI_mem    : line-aligned request address
module fetch_stage #(
    parameter int VIRT_ADDR_WIDTH             = 32,
    parameter int ICACHE_LINE_WIDTH           = 128,
    parameter int MEM_ADDRESS_LEN             = 32,
    parameter int ICACHE_LINES                = 4,
    parameter logic [VIRT_ADDR_WIDTH-1:0] RESET_PC = 32'h0000_1000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [VIRT_ADDR_WIDTH-1:0]   PCbranch,
    input  logic                         branch_hit,
    input  logic                         wrt_en,
    input  logic [ICACHE_LINE_WIDTH-1:0] instr_from_mem,
    input  logic                         mem_data_rdy,
    input  logic                         data_filled_ack,
    output logic [VIRT_ADDR_WIDTH-1:0]   PCnext,
    output logic [VIRT_ADDR_WIDTH-1:0]   instruction,
    output logic                         reqI_mem,
    output logic [MEM_ADDRESS_LEN-1:0]   reqAddrI_mem
);

    localparam int WORD_W    = VIRT_ADDR_WIDTH;
    localparam int WORDS     = ICACHE_LINE_WIDTH / WORD_W;
    localparam int WORD_BITS = $clog2(WORDS);
    localparam int OFF_BITS  = WORD_BITS + 2;
    localparam int IDX_BITS  = $clog2(ICACHE_LINES);
    localparam int TAG_LSB   = OFF_BITS + IDX_BITS;
    localparam int TAG_W     = VIRT_ADDR_WIDTH - TAG_LSB;

    // Word alignment for loaded PCs and line alignment for miss addresses.
    localparam logic [VIRT_ADDR_WIDTH-1:0] WORD_MASK =
        {{(VIRT_ADDR_WIDTH-2){1'b1}}, 2'b00};
    localparam logic [VIRT_ADDR_WIDTH-1:0] LINE_MASK =
        {{(VIRT_ADDR_WIDTH-OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};
    localparam logic [VIRT_ADDR_WIDTH-1:0] PC_STEP = VIRT_ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MISS     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t                       state_reg, state_next;
    logic [VIRT_ADDR_WIDTH-1:0]   pc_reg, pc_next;
    logic [VIRT_ADDR_WIDTH-1:0]   miss_addr_reg, miss_addr_next;

    logic                         valid_reg [ICACHE_LINES];
    logic [TAG_W-1:0]             tag_reg   [ICACHE_LINES];
    logic [ICACHE_LINE_WIDTH-1:0] data_reg  [ICACHE_LINES];

    logic [IDX_BITS-1:0]          pc_index;
    logic [TAG_W-1:0]             pc_tag;
    logic [WORD_BITS-1:0]         pc_word;
    logic [IDX_BITS-1:0]          fill_index;
    logic [TAG_W-1:0]             fill_tag;
    logic                         hit;
    logic                         fill_en;
    logic                         redirect;
    logic [WORD_W-1:0]            line_words [WORDS];

    assign pc_index   = pc_reg[TAG_LSB-1:OFF_BITS];
    assign pc_tag     = pc_reg[VIRT_ADDR_WIDTH-1:TAG_LSB];
    assign pc_word    = pc_reg[OFF_BITS-1:2];
    assign fill_index = miss_addr_reg[TAG_LSB-1:OFF_BITS];
    assign fill_tag   = miss_addr_reg[VIRT_ADDR_WIDTH-1:TAG_LSB];

    assign hit      = valid_reg[pc_index] && (tag_reg[pc_index] == pc_tag);
    assign redirect = branch_hit && wrt_en;

    // Split the indexed line into words for the combinational word select.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
            assign line_words[gi] = data_reg[pc_index][gi*WORD_W +: WORD_W];
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN:      if (!hit)            state_next = ST_MISS;
            ST_MISS:     if (mem_data_rdy)    state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: if (data_filled_ack) state_next = ST_RUN;
            default:                          state_next = ST_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        reqI_mem    = 1'b0;
        instruction = '0;
        fill_en     = 1'b0;
        case (state_reg)
            ST_RUN:  if (hit) instruction = line_words[pc_word];
            ST_MISS: begin
                reqI_mem = 1'b1;
                fill_en  = mem_data_rdy;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // PC and miss address
    // ------------------------------------------------------------------
    always_comb begin
        // A qualified redirect wins in every state; the PC otherwise only
        // advances on a hit, so a miss replays the same address.
        pc_next = pc_reg;
        if (redirect) begin
            pc_next = PCbranch & WORD_MASK;
        end else if (state_reg == ST_RUN && hit && wrt_en) begin
            pc_next = pc_reg + PC_STEP;
        end

        miss_addr_next = miss_addr_reg;
        if (state_reg == ST_RUN && !hit) begin
            miss_addr_next = pc_reg & LINE_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg        <= RESET_PC & WORD_MASK;
            miss_addr_reg <= '0;
        end else begin
            pc_reg        <= pc_next;
            miss_addr_reg <= miss_addr_next;
        end
    end

    assign PCnext = pc_next;

    generate
        if (MEM_ADDRESS_LEN <= VIRT_ADDR_WIDTH) begin : g_addr_narrow
            assign reqAddrI_mem = miss_addr_reg[MEM_ADDRESS_LEN-1:0];
        end else begin : g_addr_wide
            assign reqAddrI_mem = {{(MEM_ADDRESS_LEN-VIRT_ADDR_WIDTH){1'b0}},
                                   miss_addr_reg};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Cache storage: one register set per line, written only by a fill
    // into the line latched at miss time.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < ICACHE_LINES; gi++) begin : g_line
            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_reg[gi] <= 1'b0;
                end else if (fill_en && fill_index == IDX_BITS'(gi)) begin
                    valid_reg[gi] <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (fill_en && fill_index == IDX_BITS'(gi)) begin
                    tag_reg[gi]  <= fill_tag;
                    data_reg[gi] <= instr_from_mem;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    logic         clk;
    logic         reset;
    logic [31:0]  PCbranch;
    logic         branch_hit;
    logic         wrt_en;
    logic [127:0] instr_from_mem;
    logic         mem_data_rdy;
    logic         data_filled_ack;
    logic [31:0]  PCnext;
    logic [31:0]  instruction;
    logic         reqI_mem;
    logic [31:0]  reqAddrI_mem;

    int n_vec;
    int n_err;

    localparam logic [31:0] BASE_A = 32'h0030_8800;
    localparam logic [31:0] BASE_B = 32'hB000_0000;
    localparam logic [31:0] BASE_C = 32'hC000_0000;
    localparam logic [31:0] BASE_D = 32'hD000_0000;

    fetch_stage dut (
        .clk             (clk),
        .reset           (reset),
        .PCbranch        (PCbranch),
        .branch_hit      (branch_hit),
        .wrt_en          (wrt_en),
        .instr_from_mem  (instr_from_mem),
        .mem_data_rdy    (mem_data_rdy),
        .data_filled_ack (data_filled_ack),
        .PCnext          (PCnext),
        .instruction     (instruction),
        .reqI_mem        (reqI_mem),
        .reqAddrI_mem    (reqAddrI_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line whose word i is base + 4*i, word 0 in the low bits.
    function automatic logic [127:0] mk_line(input logic [31:0] base);
        return {base + 32'd12, base + 32'd8, base + 32'd4, base};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("vec %0d %s = %h", n_vec, tag, obs);
        end
    endtask

    // Advance one cycle and land on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec           = 0;
        n_err           = 0;
        reset           = 1'b1;
        PCbranch        = '0;
        branch_hit      = 1'b0;
        wrt_en          = 1'b1;
        mem_data_rdy    = 1'b1;
        data_filled_ack = 1'b0;
        instr_from_mem  = mk_line(BASE_A);

        step();
        step();
        reset = 1'b0;
        #1;
        check_val("rst_pcnext", PCnext, 32'h1000);
        check_val("rst_req", {31'b0, reqI_mem}, 32'd0);
        check_val("rst_addr", reqAddrI_mem, 32'h0);
        check_val("rst_instr", instruction, 32'h0);

        // Miss cycle -> MISS
        step(); #1;
        check_val("miss_req", {31'b0, reqI_mem}, 32'd1);
        check_val("miss_addr", reqAddrI_mem, 32'h1000);
        check_val("miss_instr", instruction, 32'h0);
        check_val("miss_pcnext", PCnext, 32'h1000);

        // Fill taken -> WAIT_ACK, parks while ack is low
        step(); #1;
        check_val("wait_req", {31'b0, reqI_mem}, 32'd0);
        step();
        step(); #1;
        check_val("park_instr", instruction, 32'h0);
        check_val("park_pcnext", PCnext, 32'h1000);
        check_val("park_req", {31'b0, reqI_mem}, 32'd0);

        data_filled_ack = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val($sformatf("seqA_instr%0d", i), instruction,
                      BASE_A + 32'(4 * i));
            check_val($sformatf("seqA_pcnext%0d", i), PCnext,
                      32'h1000 + 32'(4 * (i + 1)));
            step();
        end

        // 0x1010: new line, miss
        instr_from_mem = mk_line(BASE_B);
        #1;
        check_val("m1010_instr", instruction, 32'h0);
        check_val("m1010_pcnext", PCnext, 32'h1010);
        step(); #1;
        check_val("m1010_req", {31'b0, reqI_mem}, 32'd1);
        check_val("m1010_addr", reqAddrI_mem, 32'h1010);
        step();
        step(); #1;
        check_val("h1010_instr", instruction, BASE_B);
        check_val("h1010_pcnext", PCnext, 32'h1014);

        // Branch to unaligned target during a hit
        branch_hit = 1'b1;
        PCbranch   = 32'h11FF;
        #1;
        check_val("br_pcnext", PCnext, 32'h11FC);
        step();
        branch_hit     = 1'b0;
        instr_from_mem = mk_line(BASE_C);
        #1;
        check_val("br_miss_instr", instruction, 32'h0);
        check_val("br_miss_pc", PCnext, 32'h11FC);
        step(); #1;
        check_val("br_miss_addr", reqAddrI_mem, 32'h11F0);
        step();
        step(); #1;
        check_val("h11fc_instr", instruction, BASE_C + 32'd12);
        check_val("h11fc_pcnext", PCnext, 32'h1200);

        // Stall: PC and instruction hold, unqualified branch ignored
        wrt_en = 1'b0;
        #1;
        check_val("stall_pcnext", PCnext, 32'h11FC);
        for (int i = 0; i < 3; i++) begin
            step();
            if (i == 1) begin
                branch_hit = 1'b1;
                PCbranch   = 32'h2000;
            end else begin
                branch_hit = 1'b0;
            end
            #1;
            check_val($sformatf("stall_instr%0d", i), instruction,
                      BASE_C + 32'd12);
            check_val($sformatf("stall_pc%0d", i), PCnext, 32'h11FC);
        end

        // Same index, different tag as 0x1000
        wrt_en     = 1'b1;
        branch_hit = 1'b1;
        PCbranch   = 32'h1040;
        #1;
        check_val("br1040_pcnext", PCnext, 32'h1040);
        step();
        branch_hit     = 1'b0;
        instr_from_mem = mk_line(BASE_D);
        #1;
        check_val("m1040_instr", instruction, 32'h0);
        check_val("m1040_pcnext", PCnext, 32'h1040);
        step(); #1;
        check_val("m1040_addr", reqAddrI_mem, 32'h1040);
        step();
        step(); #1;
        check_val("h1040_instr", instruction, BASE_D);
        check_val("h1040_pcnext", PCnext, 32'h1044);

        // Back to 0x1000: evicted, must miss again
        branch_hit = 1'b1;
        PCbranch   = 32'h1000;
        step();
        branch_hit     = 1'b0;
        instr_from_mem = mk_line(BASE_A);
        #1;
        check_val("evict_instr", instruction, 32'h0);
        check_val("evict_pcnext", PCnext, 32'h1000);
        step(); #1;
        check_val("evict_req", {31'b0, reqI_mem}, 32'd1);
        check_val("evict_addr", reqAddrI_mem, 32'h1000);

        // Reset while in MISS aborts the request
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("rmiss_req", {31'b0, reqI_mem}, 32'd0);
        check_val("rmiss_addr", reqAddrI_mem, 32'h0);
        check_val("rmiss_pcnext", PCnext, 32'h1000);
        check_val("rmiss_instr", instruction, 32'h0);
        step(); #1;
        check_val("rmiss_req2", {31'b0, reqI_mem}, 32'd1);
        step();
        step(); #1;
        check_val("rfill_instr", instruction, BASE_A);

        // 0x1010 was valid before the reset; it must now miss
        branch_hit = 1'b1;
        PCbranch   = 32'h1010;
        step();
        branch_hit = 1'b0;
        #1;
        check_val("inval_instr", instruction, 32'h0);
        check_val("inval_pcnext", PCnext, 32'h1010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
